// File: rtl/sync_debounce_pkg.sv
// Shared defaults and helpers for the sync_debounce input conditioner.
// Imported by the interface, the per-channel sub-module and the top level.
package sync_debounce_pkg;

    localparam int unsigned DefaultWidth          = 3;
    localparam int unsigned DefaultStages         = 3;
    localparam int unsigned DefaultDebounceCycles = 4;

    // Counter must hold 0..cycles-1; one bit minimum even when cycles == 1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_if.sv
// Channel bundle between a board-input conditioner and its consumer.
// The conditioner takes the slave view; whoever drives d_in takes master.
interface sync_debounce_if
    import sync_debounce_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output d_in,
        input  d_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  d_in,
        output d_out,
        output rise,
        output fall,
        output changed
    );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: STAGES-deep metastability chain, stability counter,
// accepted level and registered single-cycle rise/fall strobes.
module debounce_channel
    import sync_debounce_pkg::*;
#(
    parameter int unsigned STAGES          = DefaultStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic d_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned          CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]      CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    logic            sync_val;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
        end
    end

    assign sync_val = sync_q[STAGES-1];

    // A single disagreeing cycle is enough to restart the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_val != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_val;
                rise_d  = sync_val;
                fall_d  = ~sync_val;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign d_out = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchroniser + debouncer for asynchronous board inputs,
// producing clean levels, per-bit edge strobes and a combined change flag.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = DefaultWidth,
    parameter int unsigned      STAGES          = DefaultStages,
    parameter int unsigned      DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic            clk,
    input  logic            reset,
    sync_debounce_if.slave  bus
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[i])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .d_in  (bus.d_in[i]),
            .d_out (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // Strobes are already registered per channel, so changed lines up with them.
    assign bus.d_out   = level;
    assign bus.rise    = rise;
    assign bus.fall    = fall;
    assign bus.changed = |(rise | fall);

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Parametrised multi-channel input conditioner for asynchronous board inputs (buttons, switches, mode straps) entering the PL pixel/system clock domain. Each channel passes through an N-flop metastability chain, then a per-channel debounce counter that accepts a new level only after it has been stable for a programmable number of cycles. The block emits a clean level plus single-cycle rise/fall strobes, so downstream game-control FSMs need no edge detectors of their own. It supersedes the fixed 3-bit, 3-stage synchroniser wherever glitch rejection or edge events are needed.

## Interface
- WIDTH, 3: number of independent channels (≥1)
- STAGES, 3: synchroniser flop depth (≥2)
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a new level (≥1); counter width is $clog2(DEBOUNCE_CYCLES+1)
- RESET_VAL, '0: WIDTH-bit reset value of every chain flop and of d_out
- clk  in  1  single clock; all logic is posedge clk
- reset  in  1  asynchronous, active-high; clears every flop immediately
- d_in  in  WIDTH  asynchronous raw inputs
- d_out  out  WIDTH  synchronised, debounced level
- rise  out  WIDTH  one-cycle pulse when a d_out bit goes 0→1
- fall  out  WIDTH  one-cycle pulse when a d_out bit goes 1→0
- changed  out  1  OR of rise|fall, registered with them

## Operation
- Per channel: sync chain s[0..STAGES-1]; s[0] <= d_in, s[i] <= s[i-1]. Let `sv = s[STAGES-1]`.
- Counter `cnt` per channel:
  - sv == d_out: cnt <= 0, no event.
  - sv != d_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sv != d_out and cnt == DEBOUNCE_CYCLES-1: d_out <= sv, cnt <= 0, rise <= sv, fall <= ~sv.
- Any cycle where sv returns to d_out before acceptance clears cnt: a glitch shorter than DEBOUNCE_CYCLES cycles at sv is fully rejected, and no partial count carries over.
- rise/fall/changed are registered and cleared to 0 on every cycle without an acceptance; never high more than one cycle per acceptance.
- Channels are fully independent; simultaneous acceptances on several channels assert several rise/fall bits in the same cycle, with changed = 1 once.
- Counter never wraps: saturates by construction at DEBOUNCE_CYCLES-1.

## Timing
- Reset values: s = RESET_VAL, d_out = RESET_VAL, cnt = 0, rise = fall = 0, changed = 0. Reset asserts asynchronously, including mid-count, and discards any pending count; no edge strobe after deassertion if d_in equals RESET_VAL.
- Latency: d_in settled before edge 1 → sv valid after edge STAGES → d_out, rise/fall valid after edge STAGES+DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES=1: d_out = sv delayed one cycle, every sv transition produces a strobe; total latency STAGES+1.
- d_in toggling faster than DEBOUNCE_CYCLES: d_out holds indefinitely.

## Structure
- No shared package required; counter width derived locally via $clog2. If the team's common `pl_pkg` exists, place the default DEBOUNCE_CYCLES for ~10 ms at the board clock there as a named constant.
- One sub-module: `debounce_channel` (1-bit chain + counter + strobes, params STAGES, DEBOUNCE_CYCLES, RESET_BIT), instantiated WIDTH times via generate; top level only ORs strobes into changed (registered per channel, OR of registered strobes).
- Add synchronizer ASYNC_REG attributes on chain flops in the sub-module.

## Test plan
- Reset: hold reset with d_in=3'b111 -> d_out=000, rise=fall=000; release, d_in stays 111 -> d_out=111 with rise=111, changed=1 exactly 7 edges later (STAGES=3, DEBOUNCE=4), one cycle only.
- Clean edge: d_in[0] 0→1 and held -> rise[0]=1 for one cycle at edge 7, d_out[0]=1 thereafter; then 1→0 -> fall[0] one cycle 7 edges later.
- Glitch: d_in[1] high for 3 cycles then low -> d_out[1] stays 0, no strobes; high for 4 cycles -> accepted.
- Bounce: d_in[2] pattern 1,0,1,1,0,1,1,1,1,… -> a single rise[2], timed 4 stable cycles after the last bounce, cnt never exceeds 3.
- Simultaneous: all channels 0→1 on the same edge -> rise=111 in one cycle, changed=1 for one cycle.
- Reset mid-count: d_in[0] high, assert reset at count 2 -> d_out, cnt, strobes cleared immediately; after release, full 7-edge latency restarts.
- Param sweep: STAGES=2, DEBOUNCE_CYCLES=1, WIDTH=8 -> latency 3 edges, every toggle strobed.
